// File: rtl/rformat_issue_ctrl.sv
// rformat_issue_ctrl
// Sequences LEGv8 R-format instructions through an external register file +
// ALU datapath. Each instruction takes three states: IDLE (accept), EXEC
// (the datapath settles and its result is captured), WB (write-back plus the
// done/illegal pulse). A preload port writes registers directly while IDLE.
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high. instr_ready is combinational and depends only on
// the state, ld_valid and reset, never on instr_valid. A pending preload takes
// priority and holds instr_ready low, so the instruction waits.
//
// All datapath-facing outputs are registered. The FSM state is exposed on
// state_dbg (0 = IDLE, 1 = EXEC, 2 = WB).

module rformat_issue_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    // instruction stream
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    // register preload
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    // datapath read/ALU control
    output logic [ADDR_W-1:0] Read1,
    output logic [ADDR_W-1:0] Read2,
    output logic [10:0]       Opcode_field,
    output logic [1:0]        ALUOp,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic              Zero,
    // datapath write-back
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              RegWrite,
    // status
    output logic              done,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              illegal,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;
    localparam logic [1:0]  ALUOP_RTYPE = 2'b10;
    localparam logic [4:0]  RD_XZR = 5'd31;

    // Instruction field split
    logic [10:0] f_opcode;
    logic [4:0]  f_rm;
    logic [4:0]  f_rn;
    logic [4:0]  f_rd;
    logic        f_legal;
    logic [5:0]  unused_shamt;

    assign f_opcode     = instr[31:21];
    assign f_rm         = instr[20:16];
    assign unused_shamt = instr[15:10];
    assign f_rn         = instr[9:5];
    assign f_rd         = instr[4:0];

    assign f_legal = (f_opcode == OP_ADD) || (f_opcode == OP_SUB) ||
                     (f_opcode == OP_AND) || (f_opcode == OP_ORR);

    // State and registered outputs
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   read1_q, read1_d;
    logic [ADDR_W-1:0]   read2_q, read2_d;
    logic [10:0]         opcode_q, opcode_d;
    logic [1:0]          aluop_q, aluop_d;
    logic [ADDR_W-1:0]   write_reg_q, write_reg_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic                reg_write_q, reg_write_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic                res_zero_q, res_zero_d;
    logic                illegal_q, illegal_d;
    // In-flight instruction bookkeeping
    logic                legal_q, legal_d;
    logic [4:0]          rd_q, rd_d;

    assign instr_ready = (state_q == S_IDLE) && !ld_valid && !reset;

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        read1_d      = read1_q;
        read2_d      = read2_q;
        opcode_d     = opcode_q;
        aluop_d      = aluop_q;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        reg_write_d  = 1'b0;
        done_d       = 1'b0;
        res_data_d   = res_data_q;
        res_zero_d   = res_zero_q;
        illegal_d    = 1'b0;
        legal_d      = legal_q;
        rd_d         = rd_q;

        case (state_q)
            S_IDLE: begin
                if (ld_valid) begin
                    // Preload wins; the write appears on the bus next cycle.
                    reg_write_d  = 1'b1;
                    write_reg_d  = ld_addr;
                    write_data_d = ld_data;
                end else if (instr_valid && instr_ready) begin
                    read1_d  = {{(ADDR_W-5){1'b0}}, f_rn};
                    read2_d  = {{(ADDR_W-5){1'b0}}, f_rm};
                    opcode_d = f_opcode;
                    aluop_d  = ALUOP_RTYPE;
                    legal_d  = f_legal;
                    rd_d     = f_rd;
                    state_d  = S_EXEC;
                end
            end

            S_EXEC: begin
                // Datapath has settled; capture and stage write-back.
                res_data_d = ALU_result;
                res_zero_d = Zero;
                done_d     = 1'b1;
                if (!legal_q) begin
                    illegal_d = 1'b1;
                end else if (rd_q != RD_XZR) begin
                    reg_write_d  = 1'b1;
                    write_reg_d  = {{(ADDR_W-5){1'b0}}, rd_q};
                    write_data_d = ALU_result;
                end
                state_d = S_WB;
            end

            S_WB: begin
                // The write commits on this edge; release the ALU.
                aluop_d = 2'b00;
                state_d = S_IDLE;
            end

            default: begin
                aluop_d = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            read1_q      <= '0;
            read2_q      <= '0;
            opcode_q     <= '0;
            aluop_q      <= '0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            reg_write_q  <= 1'b0;
            done_q       <= 1'b0;
            res_data_q   <= '0;
            res_zero_q   <= 1'b0;
            illegal_q    <= 1'b0;
            legal_q      <= 1'b0;
            rd_q         <= '0;
        end else begin
            state_q      <= state_d;
            read1_q      <= read1_d;
            read2_q      <= read2_d;
            opcode_q     <= opcode_d;
            aluop_q      <= aluop_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            reg_write_q  <= reg_write_d;
            done_q       <= done_d;
            res_data_q   <= res_data_d;
            res_zero_q   <= res_zero_d;
            illegal_q    <= illegal_d;
            legal_q      <= legal_d;
            rd_q         <= rd_d;
        end
    end

    assign Read1        = read1_q;
    assign Read2        = read2_q;
    assign Opcode_field = opcode_q;
    assign ALUOp        = aluop_q;
    assign WriteReg     = write_reg_q;
    assign WriteData    = write_data_q;
    assign RegWrite     = reg_write_q;
    assign done         = done_q;
    assign res_data     = res_data_q;
    assign res_zero     = res_zero_q;
    assign illegal      = illegal_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_rformat_issue_ctrl.sv
// Testbench for rformat_issue_ctrl. A behavioural register file + ALU stands
// in for the datapath; expected values are hand-computed constants.

module tb_rformat_issue_ctrl;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 64;

    localparam logic [63:0] V5  = 64'h5555555555555555;
    localparam logic [63:0] V10 = 64'hAAAAAAAAAAAAAAAA;
    localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [31:0]       instr = '0;
    logic              ld_valid = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [DATA_W-1:0] ld_data = '0;
    logic [ADDR_W-1:0] Read1, Read2, WriteReg;
    logic [10:0]       Opcode_field;
    logic [1:0]        ALUOp;
    logic [DATA_W-1:0] ALU_result, WriteData, res_data;
    logic              Zero, RegWrite, done, res_zero, illegal;
    logic [1:0]        state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    rformat_issue_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .Read1(Read1), .Read2(Read2), .Opcode_field(Opcode_field), .ALUOp(ALUOp),
        .ALU_result(ALU_result), .Zero(Zero),
        .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
        .done(done), .res_data(res_data), .res_zero(res_zero),
        .illegal(illegal), .state_dbg(state_dbg)
    );

    // ---------------- datapath model ----------------
    logic [DATA_W-1:0] rf [0:63];
    initial for (int i = 0; i < 64; i++) rf[i] = '0;

    always @(posedge clock) begin
        if (RegWrite) rf[WriteReg] <= WriteData;
    end

    always_comb begin
        ALU_result = '0;
        if (ALUOp == 2'b10) begin
            case (Opcode_field)
                11'b10001011000: ALU_result = rf[Read1] + rf[Read2];
                11'b11001011000: ALU_result = rf[Read1] - rf[Read2];
                11'b10001010000: ALU_result = rf[Read1] & rf[Read2];
                11'b10101010000: ALU_result = rf[Read1] | rf[Read2];
                default:         ALU_result = '0;
            endcase
        end
        Zero = (ALU_result == '0);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (state_dbg !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
        n_cmp++;
        if ({RegWrite, done, res_zero, illegal} !== 4'b0000) begin
            n_err++; $display("FAIL rst_flags: got %b want 0000", {RegWrite, done, res_zero, illegal});
        end
        n_cmp++;
        if ({Read1, Read2, WriteReg, Opcode_field, ALUOp} !== 31'd0) begin
            n_err++; $display("FAIL rst_ctrl: got %h want 0", {Read1, Read2, WriteReg, Opcode_field, ALUOp});
        end
        n_cmp++;
        if ({WriteData, res_data} !== 128'd0) begin
            n_err++; $display("FAIL rst_data: got %h / %h want 0", WriteData, res_data);
        end
        n_cmp++;
        if (instr_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_in_reset: got %b want 0", instr_ready); end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (instr_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after: got %b want 1", instr_ready); end
    endtask

    task automatic test_preload();
        ld_valid = 1'b1; ld_addr = 6'd5; ld_data = V5;
        #1;
        n_cmp++;
        if (instr_ready !== 1'b0) begin n_err++; $display("FAIL pl_ready: got %b want 0", instr_ready); end
        tick();
        n_cmp++;
        if ({RegWrite, WriteReg} !== {1'b1, 6'd5} || WriteData !== V5) begin
            n_err++; $display("FAIL pl_x5: got rw=%b reg=%0d data=%h want 1/5/%h", RegWrite, WriteReg, WriteData, V5);
        end
        ld_addr = 6'd10; ld_data = V10;
        tick();
        n_cmp++;
        if ({RegWrite, WriteReg} !== {1'b1, 6'd10} || WriteData !== V10) begin
            n_err++; $display("FAIL pl_x10: got rw=%b reg=%0d data=%h want 1/10/%h", RegWrite, WriteReg, WriteData, V10);
        end
        ld_valid = 1'b0;
        tick();
        n_cmp++;
        if (RegWrite !== 1'b0) begin n_err++; $display("FAIL pl_pulse_end: got %b want 0", RegWrite); end
        n_cmp++;
        if (rf[5] !== V5 || rf[10] !== V10) begin
            n_err++; $display("FAIL pl_readback: got %h %h want %h %h", rf[5], rf[10], V5, V10);
        end
    endtask

    task automatic test_alu_ops();
        logic [31:0] words [4] = '{32'h8A0A00A1, 32'hAA0A00A2, 32'h8B0A00A3, 32'hCB0A00A4};
        logic [10:0] ops   [4] = '{11'b10001010000, 11'b10101010000, 11'b10001011000, 11'b11001011000};
        logic [5:0]  rds   [4] = '{6'd1, 6'd2, 6'd3, 6'd4};
        logic [63:0] exps  [4] = '{64'h0, ONES, ONES, 64'hAAAAAAAAAAAAAAAB};
        logic        zs    [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            instr = words[i]; instr_valid = 1'b1;
            #1;
            n_cmp++;
            if (instr_ready !== 1'b1) begin n_err++; $display("FAIL alu%0d_ready: got %b want 1", i, instr_ready); end
            tick();
            instr_valid = 1'b0;
            #1;
            n_cmp++;
            if (state_dbg !== 2'd1 || Read1 !== 6'd5 || Read2 !== 6'd10 || ALUOp !== 2'b10 || Opcode_field !== ops[i]) begin
                n_err++; $display("FAIL alu%0d_exec: got st=%0d r1=%0d r2=%0d aluop=%b op=%b want 1/5/10/10/%b",
                                  i, state_dbg, Read1, Read2, ALUOp, Opcode_field, ops[i]);
            end
            n_cmp++;
            if (instr_ready !== 1'b0) begin n_err++; $display("FAIL alu%0d_busy: got %b want 0", i, instr_ready); end
            tick();
            n_cmp++;
            if (state_dbg !== 2'd2 || RegWrite !== 1'b1 || WriteReg !== rds[i] || WriteData !== exps[i]) begin
                n_err++; $display("FAIL alu%0d_wb: got st=%0d rw=%b reg=%0d data=%h want 2/1/%0d/%h",
                                  i, state_dbg, RegWrite, WriteReg, WriteData, rds[i], exps[i]);
            end
            n_cmp++;
            if (done !== 1'b1 || illegal !== 1'b0 || res_data !== exps[i] || res_zero !== zs[i]) begin
                n_err++; $display("FAIL alu%0d_status: got done=%b ill=%b res=%h z=%b want 1/0/%h/%b",
                                  i, done, illegal, res_data, res_zero, exps[i], zs[i]);
            end
            tick();
            n_cmp++;
            if (state_dbg !== 2'd0 || done !== 1'b0 || RegWrite !== 1'b0 || ALUOp !== 2'b00) begin
                n_err++; $display("FAIL alu%0d_idle: got st=%0d done=%b rw=%b aluop=%b want 0/0/0/00",
                                  i, state_dbg, done, RegWrite, ALUOp);
            end
            n_cmp++;
            if (rf[rds[i]] !== exps[i]) begin
                n_err++; $display("FAIL alu%0d_readback: got %h want %h", i, rf[rds[i]], exps[i]);
            end
        end
    endtask

    task automatic test_xzr_and_illegal();
        // ADD XZR, X5, X10: result captured, nothing written
        instr = 32'h8B0A00BF; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        n_cmp++;
        if (done !== 1'b1 || RegWrite !== 1'b0 || illegal !== 1'b0 || res_data !== ONES || res_zero !== 1'b0) begin
            n_err++; $display("FAIL xzr_wb: got done=%b rw=%b ill=%b res=%h z=%b want 1/0/0/%h/0",
                              done, RegWrite, illegal, res_data, res_zero, ONES);
        end
        tick();
        n_cmp++;
        if (rf[31] !== 64'h0 || done !== 1'b0) begin
            n_err++; $display("FAIL xzr_after: got x31=%h done=%b want 0/0", rf[31], done);
        end
        // opcode 11111111111, Rd = 6
        instr = 32'hFFEA00A6; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        n_cmp++;
        if (Opcode_field !== 11'h7FF || state_dbg !== 2'd1) begin
            n_err++; $display("FAIL ill_exec: got op=%h st=%0d want 7ff/1", Opcode_field, state_dbg);
        end
        tick();
        n_cmp++;
        if (illegal !== 1'b1 || done !== 1'b1 || RegWrite !== 1'b0) begin
            n_err++; $display("FAIL ill_wb: got ill=%b done=%b rw=%b want 1/1/0", illegal, done, RegWrite);
        end
        tick();
        n_cmp++;
        if (illegal !== 1'b0 || rf[6] !== 64'h0) begin
            n_err++; $display("FAIL ill_after: got ill=%b x6=%h want 0/0", illegal, rf[6]);
        end
    endtask

    task automatic test_preload_priority();
        ld_valid = 1'b1; ld_addr = 6'd7; ld_data = 64'h1234;
        instr = 32'h8B0A00A8; instr_valid = 1'b1;
        #1;
        n_cmp++;
        if (instr_ready !== 1'b0) begin n_err++; $display("FAIL pri_ready: got %b want 0", instr_ready); end
        tick();
        ld_valid = 1'b0;
        #1;
        n_cmp++;
        if (state_dbg !== 2'd0 || RegWrite !== 1'b1 || WriteReg !== 6'd7 || WriteData !== 64'h1234) begin
            n_err++; $display("FAIL pri_load: got st=%0d rw=%b reg=%0d data=%h want 0/1/7/1234",
                              state_dbg, RegWrite, WriteReg, WriteData);
        end
        n_cmp++;
        if (instr_ready !== 1'b1) begin n_err++; $display("FAIL pri_ready2: got %b want 1", instr_ready); end
        tick();
        instr_valid = 1'b0;
        n_cmp++;
        if (state_dbg !== 2'd1 || RegWrite !== 1'b0) begin
            n_err++; $display("FAIL pri_accept: got st=%0d rw=%b want 1/0", state_dbg, RegWrite);
        end
        tick();
        n_cmp++;
        if (RegWrite !== 1'b1 || WriteReg !== 6'd8 || WriteData !== ONES) begin
            n_err++; $display("FAIL pri_wb: got rw=%b reg=%0d data=%h want 1/8/%h", RegWrite, WriteReg, WriteData, ONES);
        end
        tick();
        n_cmp++;
        if (rf[7] !== 64'h1234 || rf[8] !== ONES) begin
            n_err++; $display("FAIL pri_readback: got x7=%h x8=%h want 1234/%h", rf[7], rf[8], ONES);
        end
    endtask

    task automatic test_back_to_back();
        instr = 32'h8B0A00AB; instr_valid = 1'b1;  // ADD X11
        tick();                                     // accept
        n_cmp++;
        if (state_dbg !== 2'd1 || instr_ready !== 1'b0) begin
            n_err++; $display("FAIL b2b_exec: got st=%0d rdy=%b want 1/0", state_dbg, instr_ready);
        end
        tick();
        n_cmp++;
        if (state_dbg !== 2'd2 || instr_ready !== 1'b0) begin
            n_err++; $display("FAIL b2b_wb: got st=%0d rdy=%b want 2/0", state_dbg, instr_ready);
        end
        tick();
        n_cmp++;
        if (state_dbg !== 2'd0 || instr_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_idle: got st=%0d rdy=%b want 0/1", state_dbg, instr_ready);
        end
        instr = 32'hAA0A00AC;                       // ORR X12
        tick();                                     // second accept
        instr_valid = 1'b0;
        tick();
        n_cmp++;
        if (RegWrite !== 1'b1 || WriteReg !== 6'd12 || WriteData !== ONES) begin
            n_err++; $display("FAIL b2b_wb2: got rw=%b reg=%0d data=%h want 1/12/%h", RegWrite, WriteReg, WriteData, ONES);
        end
        tick();
        n_cmp++;
        if (rf[11] !== ONES || rf[12] !== ONES) begin
            n_err++; $display("FAIL b2b_readback: got %h %h want %h", rf[11], rf[12], ONES);
        end
    endtask

    task automatic test_reset_exec();
        instr = 32'hCB0A00A9; instr_valid = 1'b1;  // SUB X9
        tick();
        instr_valid = 1'b0;
        n_cmp++;
        if (state_dbg !== 2'd1) begin n_err++; $display("FAIL rx_exec: got %0d want 1", state_dbg); end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (state_dbg !== 2'd0 || RegWrite !== 1'b0 || done !== 1'b0 || ALUOp !== 2'b00 || Read1 !== 6'd0) begin
            n_err++; $display("FAIL rx_reset: got st=%0d rw=%b done=%b aluop=%b r1=%0d want 0/0/0/00/0",
                              state_dbg, RegWrite, done, ALUOp, Read1);
        end
        n_cmp++;
        if (instr_ready !== 1'b0) begin n_err++; $display("FAIL rx_ready_held: got %b want 0", instr_ready); end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (instr_ready !== 1'b1) begin n_err++; $display("FAIL rx_ready: got %b want 1", instr_ready); end
        tick();
        tick();
        n_cmp++;
        if (rf[9] !== 64'h0 || RegWrite !== 1'b0) begin
            n_err++; $display("FAIL rx_readback: got x9=%h rw=%b want 0/0", rf[9], RegWrite);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_preload();
        test_alu_ops();
        test_xzr_and_illegal();
        test_preload_priority();
        test_back_to_back();
        test_reset_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test sequence");
        $fatal(1);
    end

endmodule
